rambus_ram_bridge: RTL
======================

# rambus_ram_bridge

Wishbone-to-OpenRAM bridge that owns port 0 of the shared 32x256 sky130 OpenRAM macro. It sits directly downstream of a project's `rambus_wb_*` master port and also gives Caravel firmware a second Wishbone master port into the same RAM. It arbitrates between the two masters, sequences single-cycle chip-select accesses into the macro, waits out the macro's read latency, and returns data and ack to the granted master.

## Interface
Parameters:
- `READ_LATENCY`, 1: cycles from the RAM capture edge until `ram_dout0_i` is valid. Legal range is 1..3.

Ports:
- `wb_clk_i`  in  1  single clock for the bridge and the RAM clock domain.
- `wb_rst_n_i`  in  1  reset, asynchronous and active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1  project master handshake.
- `m0_sel_i`  in  4  byte write mask.
- `m0_adr_i`  in  8  word address.
- `m0_dat_i`  in  32  write data.
- `m0_ack_o`  out  1  ack to project master.
- `m0_dat_o`  out  32  read data to project master.
- `m1_*`  same set, same widths: firmware master.
- `ram_csb0_o`  out  1  chip select, active low.
- `ram_web0_o`  out  1  write enable, active low.
- `ram_wmask0_o`  out  4  byte mask.
- `ram_addr0_o`  out  8  address.
- `ram_din0_o`  out  32  write data.
- `ram_dout0_i`  in  32  read data.

## Operation
- A request is `cyc_i & stb_i`. Requests are sampled only in IDLE.
- State machine:
  - IDLE: on a request, latch the granted master and load the `ram_*` output registers (`csb=0`, `web=~we`, `wmask=we?sel:0`, `addr`, `din`). Go to ACCESS.
  - ACCESS: drive `csb=1`. On a write, go to ACK. On a read, load `wait_cnt=READ_LATENCY-1` and go to WAIT; if `READ_LATENCY==1`, go straight to the data capture below.
  - WAIT: decrement `wait_cnt`. When it reaches 0, capture `ram_dout0_i` into the granted master's `dat_o` and go to ACK.
  - ACK: the granted master's `ack_o` is high for exactly this one cycle, then return to IDLE.
- Requests are ignored during ACK. A master that keeps `stb` high is re-sampled in the following IDLE cycle as a new transaction.
- `ack_o` is registered. It is set only if that master's `cyc_i` is still high at the setting edge.
- Abort (cyc dropped mid-transaction): the RAM access still completes and a write is committed. No ack is issued. `dat_o` is still updated on a read.
- `sel=0` write: `csb` is still pulsed with `wmask=0`. Normal ack; RAM contents unchanged.
- Reads ignore `sel` and return the full word.
- `dat_o` holds the last read value for that master. The non-granted master's outputs never change.
- Reset value of every output is 0, except `ram_csb0_o=1` and `ram_web0_o=1`. Reset clears state to IDLE.
- Reset mid-transaction forces `csb` high immediately (asynchronously). No ack is ever emitted for the interrupted access.

## Timing
- E0 = first edge with the request seen in IDLE.
- `csb` is low for exactly the cycle after E0. The RAM captures at E1.
- Write: ack is high during the cycle after E1, so ack arrives 2 cycles after the request.
- Read: data is captured and ack is set at edge E(1+READ_LATENCY). Latency is 3 cycles at the default.
- Back-to-back: a held request restarts at E(ack+1). Minimum spacing is 3 cycles per write and 4 per read at the default.
- There is never more than one outstanding RAM access.

## Configuration
- `RAMBUS_RR_EN` defined: round-robin arbitration.
  - A `last_grant` register (reset value m1) decides ties: the master not granted last wins.
  - The first tie after reset goes to m0.
- `RAMBUS_RR_EN` undefined: fixed priority, m1 (firmware) beats m0 on simultaneous requests. No `last_grant` register.

## Test plan
- m0 write `adr=0x10`, `dat=0xDEADBEEF`, `sel=0xF`, then read `0x10` -> `csb` low for 1 cycle each; write ack 2 cycles after the request; read ack 3 cycles after; `m0_dat_o=0xDEADBEEF`.
- m1 writes `0x11223344` to `0x20`, then m0 writes `sel=0x2`, `dat=0x0000AA00` to `0x20`; m1 reads `0x20` -> `0x1122AA44`.
- m0 and m1 request in the same cycle, repeated 4 times:
  - Without the macro: m1 served each time before m0.
  - With `RAMBUS_RR_EN`: grants alternate m0, m1, m0, m1.
- m0 drops `cyc` one cycle after a write request to `0xFF` -> no `m0_ack_o`; a later read of `0xFF` returns the written data.
- Pulse `wb_rst_n_i` low during WAIT of a read -> `ram_csb0_o=1` and all acks 0 immediately; FSM in IDLE; the next request completes normally.
- `READ_LATENCY=3`, m1 read -> ack 5 cycles after the request, with data matching the RAM model.

Source files
------------

// File: rtl/rambus_ram_bridge.sv
//------------------------------------------------------------------------------
// Module      : rambus_ram_bridge
// Description : Two-master Wishbone to OpenRAM port-0 bridge. Arbitrates the
//               project master (m0) and the firmware master (m1), issues one
//               single-cycle chip-select access at a time, waits out the
//               macro read latency and returns data/ack to the granted master.
//               Optional macro RAMBUS_RR_EN selects round-robin arbitration;
//               without it m1 has fixed priority over m0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rambus_ram_bridge #(
  parameter int READ_LATENCY = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [7:0]  m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [7:0]  m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,

  output logic        ram_csb0_o,
  output logic        ram_web0_o,
  output logic [3:0]  ram_wmask0_o,
  output logic [7:0]  ram_addr0_o,
  output logic [31:0] ram_din0_o,
  input  logic [31:0] ram_dout0_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  // Number of extra WAIT cycles after the capture edge; 0 captures on the
  // first WAIT cycle.
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  state_e      state_q;
  logic        gnt_q;        // 0 = m0, 1 = m1
  logic        wr_q;
  logic [1:0]  wait_cnt_q;

  logic        m0_ack_q;
  logic        m1_ack_q;
  logic [31:0] m0_dat_q;
  logic [31:0] m1_dat_q;

  logic        csb_q;
  logic        web_q;
  logic [3:0]  wmask_q;
  logic [7:0]  addr_q;
  logic [31:0] din_q;

  logic        m0_req_d;
  logic        m1_req_d;
  logic        any_req_d;
  logic        gnt_d;
  logic        g_we_d;
  logic [3:0]  g_sel_d;
  logic [7:0]  g_adr_d;
  logic [31:0] g_dat_d;

  assign m0_req_d  = m0_cyc_i & m0_stb_i;
  assign m1_req_d  = m1_cyc_i & m1_stb_i;
  assign any_req_d = m0_req_d | m1_req_d;

`ifdef RAMBUS_RR_EN
  logic last_grant_q;

  // Round-robin: on a tie the master not granted last time wins.
  always_comb begin
    gnt_d = 1'b0;
    if (m0_req_d && m1_req_d) begin
      gnt_d = ~last_grant_q;
    end else if (m1_req_d) begin
      gnt_d = 1'b1;
    end
  end

  // Remember the most recent grant; resetting to m1 hands the first tie to m0.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      last_grant_q <= 1'b1;
    end else if (state_q == ST_IDLE && any_req_d) begin
      last_grant_q <= gnt_d;
    end
  end
`else
  // Fixed priority: the firmware master wins whenever it requests.
  assign gnt_d = m1_req_d;
`endif

  // Request fields of whichever master wins this cycle.
  assign g_we_d  = gnt_d ? m1_we_i  : m0_we_i;
  assign g_sel_d = gnt_d ? m1_sel_i : m0_sel_i;
  assign g_adr_d = gnt_d ? m1_adr_i : m0_adr_i;
  assign g_dat_d = gnt_d ? m1_dat_i : m0_dat_i;

  // Main sequencer: grant, single-cycle RAM strobe, latency wait, one-cycle ack.
  // Acks are only raised if the granted master still holds cyc, so an aborted
  // access completes at the RAM silently.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      wr_q       <= 1'b0;
      wait_cnt_q <= 2'd0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_dat_q   <= 32'd0;
      m1_dat_q   <= 32'd0;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      wmask_q    <= 4'd0;
      addr_q     <= 8'd0;
      din_q      <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            gnt_q   <= gnt_d;
            wr_q    <= g_we_d;
            csb_q   <= 1'b0;
            web_q   <= ~g_we_d;
            wmask_q <= g_we_d ? g_sel_d : 4'd0;
            addr_q  <= g_adr_d;
            din_q   <= g_dat_d;
            state_q <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          csb_q <= 1'b1;
          if (wr_q) begin
            if (gnt_q) begin
              m1_ack_q <= m1_cyc_i;
            end else begin
              m0_ack_q <= m0_cyc_i;
            end
            state_q <= ST_ACK;
          end else begin
            wait_cnt_q <= WAIT_INIT;
            state_q    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (wait_cnt_q == 2'd0) begin
            if (gnt_q) begin
              m1_dat_q <= ram_dout0_i;
              m1_ack_q <= m1_cyc_i;
            end else begin
              m0_dat_q <= ram_dout0_i;
              m0_ack_q <= m0_cyc_i;
            end
            state_q <= ST_ACK;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end

        ST_ACK: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          state_q  <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_ack_o     = m0_ack_q;
  assign m0_dat_o     = m0_dat_q;
  assign m1_ack_o     = m1_ack_q;
  assign m1_dat_o     = m1_dat_q;
  assign ram_csb0_o   = csb_q;
  assign ram_web0_o   = web_q;
  assign ram_wmask0_o = wmask_q;
  assign ram_addr0_o  = addr_q;
  assign ram_din0_o   = din_q;

endmodule

`default_nettype wire
